// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: controller state encoding and
// the TX output mux select codes used by the controller, parity generator and serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_IDLE  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  function automatic logic [1:0] sel_for_state(input state_t s);
    logic [1:0] sel;
    case (s)
      ST_START:  sel = SEL_START;
      ST_DATA:   sel = SEL_DATA;
      ST_PARITY: sel = SEL_PAR;
      default:   sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Baud counter for one bit period; bit_end is high during the last clock of
// each period, after which the counter wraps. clr holds the counter at zero.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] r_baud_cnt;

  assign bit_end = (r_baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_baud_cnt <= '0;
    end else if (clr || bit_end) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start, data, optional parity and stop bits with
// serializer strobes. Define UART_TX_TWO_STOP_EN for two stop bits per frame.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       par_en,
  output logic [1:0] mux_sel,
  output logic       ser_load,
  output logic       ser_shift,
  output logic       busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  state_t           r_state, w_state_next;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_next;
  logic             r_par_en_q, w_par_en_next;
  logic [1:0]       r_mux_sel;
  logic             r_busy, r_ser_load, r_ser_shift;
  logic             w_bit_end, w_accept, w_shift, w_timer_clr, w_stop_last;

  // Counter idles at zero so every accepted frame starts with a full start bit.
  assign w_timer_clr = (r_state == ST_IDLE) || w_accept;

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_timer_clr),
    .bit_end (w_bit_end)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic r_stop2;

  // Set after the first stop bit-end; the second stop bit-end ends the frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stop2 <= 1'b0;
    end else if (r_state == ST_STOP && w_bit_end) begin
      r_stop2 <= ~r_stop2;
    end else if (r_state != ST_STOP) begin
      r_stop2 <= 1'b0;
    end
  end

  assign w_stop_last = r_stop2;
`else
  assign w_stop_last = 1'b1;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_par_en_next  = r_par_en_q;
    w_accept       = 1'b0;
    w_shift        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_valid) w_accept = 1'b1;
      end
      ST_START: begin
        if (w_bit_end) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
            w_state_next = r_par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_bit_end && w_stop_last) begin
          if (data_valid) w_accept = 1'b1;
          else            w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_accept) begin
      w_state_next   = ST_START;
      w_bit_cnt_next = '0;
      w_par_en_next  = par_en;
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_par_en_q  <= 1'b0;
      r_mux_sel   <= SEL_IDLE;
      r_busy      <= 1'b0;
      r_ser_load  <= 1'b0;
      r_ser_shift <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_par_en_q  <= w_par_en_next;
      r_mux_sel   <= sel_for_state(w_state_next);
      r_busy      <= (w_state_next != ST_IDLE);
      r_ser_load  <= w_accept;
      r_ser_shift <= w_shift;
    end
  end

  assign mux_sel   = r_mux_sel;
  assign busy      = r_busy;
  assign ser_load  = r_ser_load;
  assign ser_shift = r_ser_shift;

endmodule
